// File: rtl/mux7_rr_arbiter_pkg.sv
// Shared constants and types for the 7-requester round-robin mux arbiter.
package mux7_rr_arbiter_pkg;

    localparam int NUM_REQ = 7;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index following idx in search order, wrapping 6 back to 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return (idx >= SEL_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/mux7_rr_pick7.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick7
    import mux7_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [SEL_W:0] k;

    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        k         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = {1'b0, ptr} + (SEL_W+1)'(i);
            if (k >= (SEL_W+1)'(NUM_REQ))
                k = k - (SEL_W+1)'(NUM_REQ);
            if (!win_valid && req[k[SEL_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = k[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux7_rr_arbiter.sv
// Round-robin arbiter sharing one 7:1 mux: drives select, bounded-hold grants,
// and registers the mux output for the granted requester.
module mux7_rr_arbiter
    import mux7_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mux_y,
    output logic [SEL_W-1:0]   mux_sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               data_out,
    output logic               data_valid
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [SEL_W-1:0]   sel, sel_nx;
    logic [CNT_W-1:0]   hold_cnt, cnt_nx;
    logic [SEL_W-1:0]   srch_ptr;
    logic [SEL_W-1:0]   win_idx;
    logic               win_valid;
    logic [NUM_REQ:0]   req_x;

    assign req_x = {1'b0, req};

    // While granting, the search already starts past the current owner so a
    // release can hand over on the same edge without an idle bubble.
    assign srch_ptr = (state == GRANT) ? next_idx(sel) : ptr;

    rr_pick7 u_pick (
        .req       (req),
        .ptr       (srch_ptr),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            hold_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        cnt_nx   = hold_cnt;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nx = GRANT;
                    sel_nx   = win_idx;
                    cnt_nx   = CNT_ONE;
                end else begin
                    sel_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                if (req_x[sel] && hold_cnt < MAX_CNT) begin
                    cnt_nx = hold_cnt + 1'b1;
                end else begin
                    ptr_nx = srch_ptr;
                    if (win_valid) begin
                        sel_nx = win_idx;
                        cnt_nx = CNT_ONE;
                    end else begin
                        state_nx = IDLE;
                        sel_nx   = '0;
                        cnt_nx   = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == GRANT);
        mux_sel = sel;
        gnt     = busy ? (NUM_REQ'(1) << sel) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (busy)
                data_out <= mux_y;
            data_valid <= busy;
        end
    end

endmodule
